// File: rtl/adder_tree_acc.sv
// Pipelined N-input signed adder tree with per-frame accumulation, beat count and overflow flag.
// Build option: define ADDER_TREE_ACC_SAT_EN for a saturating accumulator (default wraps).
module adder_tree_acc #(
    parameter int unsigned  N          = 32,
    parameter int unsigned  DATA_WIDTH = 18,
    parameter int unsigned  ACC_EXTRA  = 8,
    parameter int unsigned  BEAT_WIDTH = 16,
    localparam int unsigned L          = $clog2(N),
    localparam int unsigned TREE_WIDTH = DATA_WIDTH + $clog2(N),
    localparam int unsigned ACC_WIDTH  = TREE_WIDTH + ACC_EXTRA
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clock_ena,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic signed [DATA_WIDTH-1:0] data [N-1:0],
    output logic                         out_valid,
    output logic signed [ACC_WIDTH-1:0]  out_sum,
    output logic        [BEAT_WIDTH-1:0] out_beats,
    output logic                         out_ovf
);

    localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Number of live nodes after lv pairwise-reduction levels.
    function automatic int level_count(input int lv);
        return (int'(N) + (1 << lv) - 1) >> lv;
    endfunction

    // ------------------------------------------------------------------
    // Adder tree: every node is kept at TREE_WIDTH; the sums are exact.
    // ------------------------------------------------------------------
    logic signed [TREE_WIDTH-1:0] tree_q [L][N];
    logic signed [TREE_WIDTH-1:0] tree_d [L][N];
    logic        [L-1:0]          vld_q;
    logic        [L-1:0]          lst_q;

    always_comb begin
        int ia;
        int ib;
        int lvp;
        logic signed [TREE_WIDTH-1:0] op_a;
        logic signed [TREE_WIDTH-1:0] op_b;
        ia   = 0;
        ib   = 0;
        lvp  = 0;
        op_a = '0;
        op_b = '0;
        for (int lv = 0; lv < L; lv++) begin
            for (int j = 0; j < N; j++) begin
                tree_d[lv][j] = '0;
            end
        end
        for (int lv = 0; lv < L; lv++) begin
            lvp = (lv == 0) ? 0 : lv - 1;
            for (int j = 0; j < N; j++) begin
                if (j < level_count(lv + 1)) begin
                    ia   = (2 * j < N) ? 2 * j : N - 1;
                    ib   = (2 * j + 1 < N) ? 2 * j + 1 : N - 1;
                    op_a = (lv == 0) ? TREE_WIDTH'(data[ia]) : tree_q[lvp][ia];
                    op_b = (lv == 0) ? TREE_WIDTH'(data[ib]) : tree_q[lvp][ib];
                    // An unpaired tail node passes through so every path has L registers.
                    if (2 * j + 1 < level_count(lv)) begin
                        tree_d[lv][j] = op_a + op_b;
                    end else begin
                        tree_d[lv][j] = op_a;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int lv = 0; lv < L; lv++) begin
                for (int j = 0; j < N; j++) begin
                    tree_q[lv][j] <= '0;
                end
            end
            vld_q <= '0;
            lst_q <= '0;
        end else if (clock_ena) begin
            tree_q   <= tree_d;
            vld_q[0] <= in_valid;
            lst_q[0] <= in_valid & in_last;
            for (int lv = 1; lv < L; lv++) begin
                vld_q[lv] <= vld_q[lv-1];
                lst_q[lv] <= lst_q[lv-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame accumulator
    // ------------------------------------------------------------------
    logic                         tree_vld;
    logic                         tree_lst;
    logic signed [ACC_WIDTH-1:0]  addend;
    logic signed [ACC_WIDTH-1:0]  sum_raw;
    logic signed [ACC_WIDTH-1:0]  acc_step;
    logic                         sum_ovf;

    logic                         first_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic        [BEAT_WIDTH-1:0] beats_q;
    logic        [BEAT_WIDTH-1:0] beats_d;
    logic                         ovf_q;
    logic                         ovf_d;
    logic                         frame_done_q;

    logic                         out_valid_q;
    logic signed [ACC_WIDTH-1:0]  out_sum_q;
    logic        [BEAT_WIDTH-1:0] out_beats_q;
    logic                         out_ovf_q;

    assign tree_vld = vld_q[L-1];
    assign tree_lst = lst_q[L-1];

    always_comb begin
        addend  = ACC_WIDTH'(tree_q[L-1][0]);
        sum_raw = acc_q + addend;
        sum_ovf = (acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                  (sum_raw[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
`ifdef ADDER_TREE_ACC_SAT_EN
        if (sum_ovf) begin
            acc_step = acc_q[ACC_WIDTH-1] ? AccMin : AccMax;
        end else begin
            acc_step = sum_raw;
        end
`else
        acc_step = sum_raw;
`endif
        if (first_q) begin
            acc_d   = addend;
            beats_d = BEAT_WIDTH'(1);
            ovf_d   = 1'b0;
        end else begin
            acc_d   = acc_step;
            beats_d = (&beats_q) ? beats_q : beats_q + 1'b1;
            ovf_d   = ovf_q | sum_ovf;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            first_q      <= 1'b1;
            acc_q        <= '0;
            beats_q      <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_beats_q  <= '0;
            out_ovf_q    <= 1'b0;
        end else if (clock_ena) begin
            if (tree_vld) begin
                acc_q   <= acc_d;
                beats_q <= beats_d;
                ovf_q   <= ovf_d;
                first_q <= tree_lst;
            end
            frame_done_q <= tree_vld & tree_lst;
            // Result copy runs one edge behind, so a back-to-back first beat can reload acc_q.
            out_valid_q  <= frame_done_q;
            if (frame_done_q) begin
                out_sum_q   <= acc_q;
                out_beats_q <= beats_q;
                out_ovf_q   <= ovf_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: N=4 and N=5 instances share stimulus, checked against a frame model.
module tb_adder_tree_acc;

    typedef struct {
        int     due;
        longint sum;
        int     beats;
        bit     ovf;
    } pend_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              clock_ena;
    logic              in_valid;
    logic              in_last;
    logic signed [7:0] d5 [4:0];
    logic signed [7:0] d4 [3:0];

    logic              ov4;
    logic signed [11:0] sum4;
    logic       [15:0] beats4;
    logic              ovf4;
    logic              ov5;
    logic signed [12:0] sum5;
    logic       [15:0] beats5;
    logic              ovf5;

    always #5 clock = ~clock;

    always_comb begin
        for (int k = 0; k < 4; k++) d4[k] = d5[k];
    end

    adder_tree_acc #(.N(4), .DATA_WIDTH(8), .ACC_EXTRA(2), .BEAT_WIDTH(16)) u_dut4 (
        .clock(clock), .reset(reset), .clock_ena(clock_ena), .in_valid(in_valid),
        .in_last(in_last), .data(d4), .out_valid(ov4), .out_sum(sum4),
        .out_beats(beats4), .out_ovf(ovf4)
    );

    adder_tree_acc #(.N(5), .DATA_WIDTH(8), .ACC_EXTRA(2), .BEAT_WIDTH(16)) u_dut5 (
        .clock(clock), .reset(reset), .clock_ena(clock_ena), .in_valid(in_valid),
        .in_last(in_last), .data(d5), .out_valid(ov5), .out_sum(sum5),
        .out_beats(beats5), .out_ovf(ovf5)
    );

    // Model state, index 0 = N=4 instance, index 1 = N=5 instance.
    int     nvec = 0;
    int     nerr = 0;
    int     ecount = 0;
    int     nl  [2];
    int     aw  [2];
    int     lat [2];
    longint facc   [2];
    int     fbeats [2];
    bit     fovf   [2];
    bit     ffirst [2];
    bit     exp_v     [2];
    longint exp_sum   [2];
    int     exp_beats [2];
    bit     exp_ovf   [2];
    pend_t  q0 [$];
    pend_t  q1 [$];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(input int a, input int b, input int c, input int d, input int f);
        d5[0] = 8'(a);
        d5[1] = 8'(b);
        d5[2] = 8'(c);
        d5[3] = 8'(d);
        d5[4] = 8'(f);
    endtask

    task automatic publish(input int i, input pend_t p);
        exp_v[i]     = 1'b1;
        exp_sum[i]   = p.sum;
        exp_beats[i] = p.beats;
        exp_ovf[i]   = p.ovf;
    endtask

    task automatic add_beat(input int i, input bit l);
        longint s;
        longint t;
        longint hi;
        longint lo;
        pend_t  p;
        s  = 0;
        for (int k = 0; k < nl[i]; k++) s += longint'(d5[k]);
        hi = (longint'(1) <<< (aw[i] - 1)) - 1;
        lo = -(longint'(1) <<< (aw[i] - 1));
        if (ffirst[i]) begin
            facc[i]   = s;
            fbeats[i] = 1;
            fovf[i]   = 1'b0;
        end else begin
            t = facc[i] + s;
            if (t > hi || t < lo) fovf[i] = 1'b1;
`ifdef ADDER_TREE_ACC_SAT_EN
            if (t > hi) t = hi;
            else if (t < lo) t = lo;
`else
            if (t > hi) t = t - 2 * (hi + 1);
            else if (t < lo) t = t + 2 * (hi + 1);
`endif
            facc[i]   = t;
            fbeats[i] = (fbeats[i] == 65535) ? 65535 : fbeats[i] + 1;
        end
        ffirst[i] = 1'b0;
        if (l) begin
            p.due   = ecount + lat[i];
            p.sum   = facc[i];
            p.beats = fbeats[i];
            p.ovf   = fovf[i];
            if (i == 0) q0.push_back(p);
            else q1.push_back(p);
            ffirst[i] = 1'b1;
        end
    endtask

    task automatic model(input bit r, input bit e, input bit v, input bit l);
        pend_t p;
        if (r) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
                ffirst[i] = 1'b1; facc[i] = 0; fbeats[i] = 0; fovf[i] = 1'b0;
                exp_v[i] = 1'b0; exp_sum[i] = 0; exp_beats[i] = 0; exp_ovf[i] = 1'b0;
            end
        end else if (e) begin
            ecount++;
            exp_v[0] = 1'b0;
            exp_v[1] = 1'b0;
            if (q0.size() > 0 && q0[0].due == ecount) begin
                p = q0.pop_front();
                publish(0, p);
            end
            if (q1.size() > 0 && q1[0].due == ecount) begin
                p = q1.pop_front();
                publish(1, p);
            end
            if (v) begin
                add_beat(0, l);
                add_beat(1, l);
            end
        end
    endtask

    task automatic check_all();
        chk("valid4", ov4, exp_v[0]);
        chk("sum4", sum4, 32'(exp_sum[0]));
        chk("beats4", beats4, exp_beats[0]);
        chk("ovf4", ovf4, exp_ovf[0]);
        chk("valid5", ov5, exp_v[1]);
        chk("sum5", sum5, 32'(exp_sum[1]));
        chk("beats5", beats5, exp_beats[1]);
        chk("ovf5", ovf5, exp_ovf[1]);
    endtask

    task automatic cycle(input bit r, input bit e, input bit v, input bit l);
        reset     = r;
        clock_ena = e;
        in_valid  = v;
        in_last   = l;
        @(posedge clock);
        model(r, e, v, l);
        #1 check_all();
    endtask

    initial begin
        nl  = '{4, 5};
        aw  = '{12, 13};
        lat = '{3, 4};
        set_lanes(0, 0, 0, 0, 0);

        // Reset state
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        chk("rst_valid", ov4, 0);
        chk("rst_sum", sum4, 0);

        // Single beat, latency L+1
        set_lanes(1, 2, 3, 4, 5);
        cycle(0, 1, 1, 1);
        set_lanes(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("s1_early", ov4, 0);
        cycle(0, 1, 0, 0);
        chk("s1_valid4", ov4, 1);
        chk("s1_sum4", sum4, 10);
        chk("s1_beats4", beats4, 1);
        chk("s1_early5", ov5, 0);
        cycle(0, 1, 0, 0);
        chk("s1_valid5", ov5, 1);
        chk("s1_sum5", sum5, 15);
        chk("s1_drop4", ov4, 0);
        cycle(0, 1, 0, 0);

        // Three-beat frame with cancelling extremes
        set_lanes(127, 127, 127, 127, 0);
        cycle(0, 1, 1, 0);
        set_lanes(-128, -128, -128, -128, 0);
        cycle(0, 1, 1, 0);
        set_lanes(5, 5, 5, 5, 0);
        cycle(0, 1, 1, 1);
        for (int k = 0; k < 5; k++) cycle(0, 1, 0, 0);
        chk("s2_sum4", sum4, 16);
        chk("s2_beats4", beats4, 3);

        // Back-to-back single-beat frames
        set_lanes(1, 1, 1, 1, 1);
        cycle(0, 1, 1, 1);
        set_lanes(2, 2, 2, 2, 2);
        cycle(0, 1, 1, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("s3_sum_a", sum4, 4);
        cycle(0, 1, 0, 0);
        chk("s3_valid_b", ov4, 1);
        chk("s3_sum_b", sum4, 8);
        chk("s3_beats_b", beats4, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);

        // Stall after acceptance
        set_lanes(1, 2, 3, 4, 5);
        cycle(0, 1, 1, 1);
        cycle(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0);
        chk("s4_frozen", ov4, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("s4_sum", sum4, 10);

        // Stall while a pulse is showing
        set_lanes(3, 3, 3, 3, 3);
        cycle(0, 1, 1, 1);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("s4_hold", ov4, 1);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0);

        // Overflowing frame then a clean frame
        set_lanes(127, 127, 127, 127, 127);
        for (int k = 0; k < 4; k++) cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 1);
        set_lanes(1, 1, 1, 1, 1);
        cycle(0, 1, 1, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
`ifdef ADDER_TREE_ACC_SAT_EN
        chk("s5_sum", sum4, 2047);
`else
        chk("s5_sum", sum4, -1556);
`endif
        chk("s5_ovf", ovf4, 1);
        cycle(0, 1, 0, 0);
        chk("s5_next_sum", sum4, 4);
        chk("s5_next_ovf", ovf4, 0);
        for (int k = 0; k < 2; k++) cycle(0, 1, 0, 0);

        // Reset aborts a partial frame
        set_lanes(10, 10, 10, 10, 10);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(1, 1, 0, 0);
        set_lanes(1, 2, 3, 4, 5);
        cycle(0, 1, 1, 1);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("s6_no_pulse", ov4, 0);
        cycle(0, 1, 0, 0);
        chk("s6_sum", sum4, 10);
        chk("s6_beats", beats4, 1);
        chk("s6_ovf", ovf4, 0);
        for (int k = 0; k < 2; k++) cycle(0, 1, 0, 0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            int pick;
            pick = $urandom_range(0, 9);
            if (pick == 0) set_lanes(127, 127, 127, 127, 127);
            else if (pick == 1) set_lanes(-128, -128, -128, -128, -128);
            else set_lanes($urandom, $urandom, $urandom, $urandom, $urandom);
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25);
        end
        for (int k = 0; k < 6; k++) cycle(0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/adder_tree_acc.md
Name: adder_tree_acc

Overview:
- Parametrised successor to the pipelined N-input signed adder tree.
- Adds a valid/last pipeline, a global clock enable and synchronous reset.
- Sums each N-wide beat through a registered binary tree, then accumulates tree results over a frame of beats delimited by in_last.
- Emits one summed result per frame, with beat count and overflow flag. Sits behind vector/MAC datapaths feeding per-frame reductions.

Parameters:
- N, 32, number of input lanes; N >= 2, odd N allowed.
- DATA_WIDTH, 18, signed lane width.
- ACC_EXTRA, 8, guard bits added to the accumulator above the tree width.
- BEAT_WIDTH, 16, width of the per-frame beat counter.
- Derived (localparam): L = $clog2(N).
- Derived (localparam): TREE_WIDTH = DATA_WIDTH + $clog2(N).
- Derived (localparam): ACC_WIDTH = TREE_WIDTH + ACC_EXTRA.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high.
- clock_ena, input, 1: global advance enable; low freezes every register.
- in_valid, input, 1: beat present on data.
- in_last, input, 1: final beat of the frame; qualified by in_valid.
- data, input, N x DATA_WIDTH, unpacked array data[N-1:0], signed lanes.
- out_valid, output, 1: one-cycle pulse, frame result valid.
- out_sum, output, ACC_WIDTH signed: frame sum.
- out_beats, output, BEAT_WIDTH: beats in the frame, saturating at all-ones.
- out_ovf, output, 1: accumulator overflowed at least once during the frame.

Behaviour:
- All register updates occur only when clock_ena=1; reset has priority over clock_ena.
- Reset values: out_valid=0, out_sum=0, out_beats=0, out_ovf=0. Reset also clears all valid/last pipeline bits, the accumulator, beat counter and sticky overflow.
- Tree: L registered levels. Each level adds adjacent pairs, result one bit wider than its inputs. An odd leftover element is sign-extended and registered unchanged, so all paths stay aligned.
- valid and last travel with the data through L register stages.
- Tree outputs TREE_WIDTH bits, exact with no overflow possible.
- Accumulator stage, on a tree-output beat with valid=1:
  - If it is the first beat of a frame, acc is loaded with sext(tree), beats=1 and ovf=0.
  - Otherwise acc = acc + sext(tree), beats increments (saturating) and ovf |= signed overflow.
  - Signed overflow means both operands have the same sign and the sum has a different sign.
- "First beat" flag: set by reset and after every last beat; cleared by any non-last valid beat.
- On a valid beat with last=1: out_valid=1 next enabled edge, out_sum, out_beats and out_ovf take the final frame values, and the frame state resets for the next beat. Back-to-back frames need no gap.
- out_valid is 0 on any edge without a completed frame. out_sum/out_beats/out_ovf hold their last values between pulses.
- Latency: in_valid&in_last accepted at enabled edge k -> out_valid high after enabled edge k+L+1.
- Throughput: one beat per enabled cycle, no backpressure.
- in_last with in_valid=0 is ignored.
- clock_ena=0: all state frozen, including out_valid. A pending pulse stays high until the next enabled edge.
- Reset mid-frame discards the partial frame and all in-flight tree beats. No output is produced for the aborted frame.

Optional Feature:
- Macro: ADDER_TREE_ACC_SAT_EN.
- Defined: each accumulate is saturating, clamped to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1). Once clamped, later beats continue from the clamped value. out_ovf is still set.
- Undefined: two's-complement wrap modulo 2^ACC_WIDTH. out_ovf is set on wrap.

Test Plan:
Configuration for all scenarios: N=4, DATA_WIDTH=8, ACC_EXTRA=2, giving L=2, ACC_WIDTH=12, range -2048..2047.
1. Single beat {1,2,3,4}, valid+last, clock_ena=1 -> out_valid pulses exactly 3 cycles later, sum=10, beats=1, ovf=0. Repeat with N=5 {1,2,3,4,5} -> sum=15, latency 4.
2. Frame {127x4},{-128x4},{5x4}, last on the third beat -> sum=16, beats=3, single pulse.
3. Consecutive cycles: frame {1x4}+last, then frame {2x4}+last -> out_valid high two consecutive cycles, sums 4 then 8, beats 1 and 1.
4. Beat {1,2,3,4}+last, then clock_ena=0 for 5 cycles starting one cycle later -> all outputs frozen during the stall; pulse arrives after 3 enabled edges total, sum=10.
5. Five beats of {127x4}+last on the fifth -> wrap build: sum=-1556, ovf=1; SAT build: sum=2047, ovf=1. Next frame {1x4} -> sum=4, ovf=0.
6. Two non-last beats {10x4}, reset one cycle, then {1,2,3,4}+last -> no pulse for the aborted frame; next pulse sum=10, beats=1, ovf=0.
